// File: rtl/full_adder_pkg.sv
// full_adder_pkg
//   Shared constants for the ripple-carry adder slice.
//   WIDTH_DEFAULT : operand width used when the top is not overridden
//   WIDTH_MAX     : widest operand the adder is intended to be built at
package full_adder_pkg;

  localparam int WIDTH_DEFAULT = 1;
  localparam int WIDTH_MAX     = 64;

endpackage : full_adder_pkg

// File: rtl/full_adder_fa_bit.sv
// fa_bit
//   One-bit full adder cell, pure dataflow. It is chained by full_adder to
//   build the ripple-carry adder.
//   Ports:
//     a, b : addend bits
//     cin  : carry into this bit
//     sum  : a ^ b ^ cin
//     co   : carry out of this bit
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic co
);

  // Plain gate equations, so an X on any input shows up as X on the
  // outputs instead of being resolved by a case/if structure.
  logic half_sum;

  assign half_sum = a ^ b;
  assign sum      = half_sum ^ cin;
  assign co       = (a & b) | (cin & half_sum);

endmodule : fa_bit

// File: rtl/full_adder.sv
// full_adder
//   WIDTH-bit ripple-carry adder with a combinational result and a copy of
//   the result registered one clock later.
//   Ports:
//     a, b   : addends, WIDTH bits
//     cin    : carry-in into bit 0
//     sum    : combinational sum, WIDTH bits
//     co     : combinational carry-out of the top bit
//     clk    : rising-edge clock, used only by sum_r / co_r
//     rst_n  : asynchronous active-low reset, clears only sum_r / co_r
//     sum_r  : sum captured on the last rising clk edge
//     co_r   : co captured on the last rising clk edge
//   The port order lets a five-port positional instance (a, b, cin, sum, co)
//   leave the clock, reset and registered outputs unconnected.
//   Legal WIDTH range is 1 .. WIDTH_MAX.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] sum_r,
  output logic             co_r
);

  // carry[i] is the carry into bit i; carry[WIDTH] leaves the top bit.
  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ripple
      fa_bit u_fa_bit (
        .a   (a[gi]),
        .b   (b[gi]),
        .cin (carry[gi]),
        .sum (sum[gi]),
        .co  (carry[gi+1])
      );
    end
  endgenerate

  assign co = carry[WIDTH];

  // Output register. Reset takes effect immediately; release is only seen
  // through the next rising edge, which is then the first capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r <= '0;
      co_r  <= 1'b0;
    end else begin
      sum_r <= sum;
      co_r  <= co;
    end
  end

endmodule : full_adder

// File: tb/tb_full_adder.sv
module tb_full_adder;

  typedef struct {
    logic       a;
    logic       b;
    logic       cin;
    logic       sum;
    logic       co;
  } vec1_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       co;
  } vec8_t;

  logic       clk;
  logic       rst_n;

  logic       a1, b1, cin1, sum1, co1, sum_r1, co_r1;
  logic [7:0] a8, b8, sum8, sum_r8;
  logic       cin8, co8, co_r8;

  int vec_cnt;
  int err_cnt;

  vec1_t t1[8];
  vec8_t t8[8];

  full_adder #(.WIDTH(1)) dut1 (
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .sum   (sum1),
    .co    (co1),
    .clk   (clk),
    .rst_n (rst_n),
    .sum_r (sum_r1),
    .co_r  (co_r1)
  );

  full_adder #(.WIDTH(8)) dut8 (
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .sum   (sum8),
    .co    (co8),
    .clk   (clk),
    .rst_n (rst_n),
    .sum_r (sum_r8),
    .co_r  (co_r8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;

    // Hand-computed truth table for one bit, index = {a,b,cin}.
    t1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    t1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    t1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    t1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    t1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    t1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    t1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    t1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Eight-bit vectors, including the carry-out boundaries.
    t8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    t8[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    t8[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    t8[3] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    t8[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    t8[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    t8[6] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
    t8[7] = '{8'h3C, 8'hC3, 1'b1, 8'h00, 1'b1};

    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;

    // Reset state of the registered outputs.
    #1;
    check("rst_sum_r1", 64'(sum_r1), 64'd0);
    check("rst_co_r1",  64'(co_r1),  64'd0);
    check("rst_sum_r8", 64'(sum_r8), 64'd0);
    check("rst_co_r8",  64'(co_r8),  64'd0);

    // One-bit truth table, combinational, applied while reset is held:
    // sum/co must track inputs and the registers must stay cleared.
    for (int i = 0; i < 8; i++) begin
      a1 = t1[i].a; b1 = t1[i].b; cin1 = t1[i].cin;
      #1;
      $display("w1 comb %0d: a=%b b=%b cin=%b -> sum=%b co=%b sum_r=%b co_r=%b",
               i, a1, b1, cin1, sum1, co1, sum_r1, co_r1);
      check("w1_sum", 64'(sum1), 64'(t1[i].sum));
      check("w1_co",  64'(co1),  64'(t1[i].co));
      check("w1_rst_sum_r", 64'(sum_r1), 64'd0);
      check("w1_rst_co_r",  64'(co_r1),  64'd0);
      #4;
    end

    // Eight-bit combinational vectors, still under reset.
    for (int i = 0; i < 8; i++) begin
      a8 = t8[i].a; b8 = t8[i].b; cin8 = t8[i].cin;
      #1;
      $display("w8 comb %0d: a=%h b=%h cin=%b -> sum=%h co=%b", i, a8, b8, cin8, sum8, co8);
      check("w8_sum", 64'(sum8), 64'(t8[i].sum));
      check("w8_co",  64'(co8),  64'(t8[i].co));
      check("w8_rst_sum_r", 64'(sum_r8), 64'd0);
      #4;
    end

    // Release reset away from the rising edge; nothing is captured until
    // the next rising edge.
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_sum_r8_before", 64'(sum_r8), 64'd0);
    @(posedge clk);
    #1;
    $display("release capture: sum_r8=%h co_r8=%b", sum_r8, co_r8);
    check("rel_sum_r8_after", 64'(sum_r8), 64'h47);
    check("rel_co_r8_after",  64'(co_r8),  64'd0);

    // One-bit latency: 011 applied before edge N, visible only after it.
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1; cin1 = 1'b1;
    #1;
    check("lat_co_r1_before",  64'(co_r1),  64'd0);
    check("lat_sum_r1_before", 64'(sum_r1), 64'd0);
    @(posedge clk);
    #1;
    $display("w1 latency: sum_r=%b co_r=%b", sum_r1, co_r1);
    check("lat_sum_r1_after", 64'(sum_r1), 64'd0);
    check("lat_co_r1_after",  64'(co_r1),  64'd1);

    // Eight-bit registered pipeline: each vector shows up exactly one edge
    // after it is applied; before that edge the previous result is held.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] prev_sum;
      logic       prev_co;
      prev_sum = (i == 0) ? 8'h47 : t8[i-1].sum;
      prev_co  = (i == 0) ? 1'b0  : t8[i-1].co;
      @(negedge clk);
      a8 = t8[i].a; b8 = t8[i].b; cin8 = t8[i].cin;
      #1;
      check("pipe_hold_sum_r", 64'(sum_r8), 64'(prev_sum));
      check("pipe_hold_co_r",  64'(co_r8),  64'(prev_co));
      @(posedge clk);
      #1;
      $display("w8 reg %0d: a=%h b=%h cin=%b -> sum_r=%h co_r=%b", i, a8, b8, cin8, sum_r8, co_r8);
      check("pipe_sum_r", 64'(sum_r8), 64'(t8[i].sum));
      check("pipe_co_r",  64'(co_r8),  64'(t8[i].co));
    end

    // Load 0x5A/1 (0xFF + 0x5A + 1 = 0x15A), then pulse reset mid-cycle.
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h5A; cin8 = 1'b1;
    @(posedge clk);
    #1;
    check("hold5a_sum_r", 64'(sum_r8), 64'h5A);
    check("hold5a_co_r",  64'(co_r8),  64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    $display("mid-cycle reset: sum=%h co=%b sum_r=%h co_r=%b", sum8, co8, sum_r8, co_r8);
    check("midrst_sum_r", 64'(sum_r8), 64'd0);
    check("midrst_co_r",  64'(co_r8),  64'd0);
    check("midrst_sum",   64'(sum8),   64'h5A);
    check("midrst_co",    64'(co8),    64'd1);

    // Combinational outputs keep tracking while reset is low.
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
    #1;
    check("rstlow_sum", 64'(sum8), 64'h02);
    check("rstlow_co",  64'(co8),  64'd0);

    // Register stays cleared across an edge while reset is low.
    @(posedge clk);
    #1;
    check("rstlow_edge_sum_r", 64'(sum_r8), 64'd0);

    // Release and confirm first capture on the following edge.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel2_before", 64'(sum_r8), 64'd0);
    @(posedge clk);
    #1;
    check("rel2_after", 64'(sum_r8), 64'h02);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule : tb_full_adder

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter WIDTH, default 1, SHALL set the operand and sum bit width; the legal range SHALL be 1..64.
REQ-002 Port clk, input, 1 bit: the single clock, rising-edge active, used only by the registered outputs.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous and active-low, acting only on the registered outputs.
REQ-004 Port a, input, WIDTH bits: addend A.
REQ-005 Port b, input, WIDTH bits: addend B.
REQ-006 Port cin, input, 1 bit: carry-in.
REQ-007 Port sum, output, WIDTH bits: combinational sum.
REQ-008 Port co, output, 1 bit: combinational carry-out.
REQ-009 Port sum_r, output, WIDTH bits: registered sum.
REQ-010 Port co_r, output, 1 bit: registered carry-out.
REQ-011 Port declaration order SHALL be a, b, cin, sum, co, clk, rst_n, sum_r, co_r, so that five-port positional instantiation with clk, rst_n, sum_r and co_r unconnected works.

Function
REQ-012 {co, sum} SHALL equal a + b + cin, evaluated at WIDTH+1 bits with no truncation.
REQ-013 For WIDTH=1: sum SHALL be a^b^cin and co SHALL be (a&b)|(cin&(a^b)).
REQ-014 sum and co SHALL be purely combinational: no latch, no clock dependence, and valid within the same delta cycle as any input change.
REQ-015 sum and co SHALL be unaffected by clk and rst_n, including while rst_n is low or floating.
REQ-016 On each rising clk edge with rst_n high, sum_r and co_r SHALL capture the current sum and co, giving exactly 1-cycle latency.
REQ-017 X or Z on any input bit SHALL propagate as X to the dependent outputs; X SHALL NOT be masked to 0 or 1.
REQ-018 Overflow SHALL be reported only through co, with no wrap flag: all-ones + all-ones + 1 gives sum all-ones and co=1.

Reset
REQ-019 While rst_n=0, sum_r SHALL be 0 and co_r SHALL be 0, with effect immediate and independent of clk.
REQ-020 Reset release SHALL be sampled synchronously: the first capture SHALL occur at the first rising clk edge after rst_n goes high.
REQ-021 Asserting reset mid-operation SHALL clear only the registered outputs; combinational outputs SHALL keep tracking the inputs.

Structure
REQ-022 Package full_adder_pkg SHALL hold the WIDTH default and the WIDTH_MAX=64 constant.
REQ-023 One sub-module, fa_bit (a, b, cin -> sum, co, dataflow equations of REQ-013), SHALL be instantiated WIDTH times as a ripple chain.
REQ-024 cin SHALL feed bit 0 of the chain, and the carry out of the top bit SHALL be co.
REQ-025 The output register SHALL be a single always block with an asynchronous reset branch.
REQ-026 The block SHALL be synthesizable with no initial blocks in RTL.

Verification
REQ-027 WIDTH=1, {a,b,cin} stepped 000..111 every 5 ns -> {sum,co} = 00,10,10,01,10,01,01,11 within the same timestep; clk and rst_n left unconnected.
REQ-028 WIDTH=1, rst_n low, inputs 111 -> sum=1 and co=1 while sum_r=0 and co_r=0.
REQ-029 WIDTH=1, rst_n high, inputs 011 applied before clk edge N -> sum_r=0 and co_r=1 after edge N, not earlier.
REQ-030 WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, co=1.
REQ-031 WIDTH=8, a=0xFF, b=0xFF, cin=1 -> sum=0xFF, co=1.
REQ-032 Registered outputs holding 0x5A/1, then rst_n pulsed low mid-cycle -> sum_r and co_r go to 0 immediately without a clk edge, while sum and co are unchanged.
